// File: rtl/bcd_updown_counter_mux.sv
// Multi-digit BCD up/down counter with a tick prescaler, synchronous load and
// a time-multiplexed active-low seven-segment display driver.
module bcd_updown_counter_mux #(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned TICK_HZ      = 4,
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned REFRESH_BITS = 18,
  parameter int unsigned BLANK_LZ     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    tick,
  output logic                    wrap
);

  localparam int unsigned DIV       = CLK_FREQ / TICK_HZ;
  localparam int unsigned PRE_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SEL_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SCAN_W    = REFRESH_BITS + ((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 0);
  localparam int unsigned SCAN_LAST = NUM_DIGITS * (1 << REFRESH_BITS) - 1;

  logic [PRE_W-1:0]                presc_q, presc_d;
  logic                            tick_q, tick_d;
  logic                            wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0][3:0]      dig_q, dig_d;
  logic [SCAN_W-1:0]               scan_q, scan_d;
  logic                            carry;
  logic [SEL_W-1:0]                sel_c;
  logic                            zero_hi;
  logic                            blank;
  logic [3:0]                      disp_dig;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0010000;
      default: seg_enc = 7'b1111111;
    endcase
  endfunction

  // Prescaler: pulses tick in the cycle after the terminal value; held at 0 while paused.
  always_comb begin
    presc_d = '0;
    tick_d  = 1'b0;
    if (en) begin
      if (presc_q == PRE_W'(DIV - 1)) begin
        tick_d = 1'b1;
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end
  end

  // Digit update: load wins over a tick; carry/borrow ripples digit by digit.
  always_comb begin
    dig_d  = dig_q;
    wrap_d = 1'b0;
    carry  = 1'b0;
    if (load) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        dig_d[i] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
      end
    end else if (tick_q && en) begin
      carry = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (carry) begin
          if (up_dn) begin
            if (dig_q[i] == 4'd9) begin
              dig_d[i] = 4'd0;
            end else begin
              dig_d[i] = dig_q[i] + 4'd1;
              carry    = 1'b0;
            end
          end else begin
            if (dig_q[i] == 4'd0) begin
              dig_d[i] = 4'd9;
            end else begin
              dig_d[i] = dig_q[i] - 4'd1;
              carry    = 1'b0;
            end
          end
        end
      end
      wrap_d = carry;
    end
  end

  // Scan counter restarts after the last digit slot so odd digit counts never idle.
  always_comb begin
    scan_d = (scan_q == SCAN_W'(SCAN_LAST)) ? '0 : scan_q + SCAN_W'(1);
  end

  assign sel_c = (NUM_DIGITS > 1) ? scan_q[SCAN_W-1 -: SEL_W] : '0;

  // Display mux; zero_hi tracks whether this digit and all above it are zero.
  always_comb begin
    an       = '1;
    zero_hi  = 1'b1;
    blank    = 1'b0;
    disp_dig = 4'd0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_hi = zero_hi & (dig_q[i] == 4'd0);
      if (sel_c == SEL_W'(i)) begin
        an[i]    = 1'b0;
        disp_dig = dig_q[i];
        blank    = (BLANK_LZ != 0) && (i != 0) && zero_hi;
      end
    end
    seg = blank ? 7'b1111111 : seg_enc(disp_dig);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      dig_q   <= '0;
      scan_q  <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      dig_q   <= dig_d;
      scan_q  <= scan_d;
    end
  end

  assign count = dig_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter_mux.sv
// Randomized bench for bcd_updown_counter_mux against an integer-arithmetic model;
// a second 3-digit instance with leading-zero blanking exercises the display path.
module tb_bcd_updown_counter_mux;

  localparam int unsigned DIV  = 8;
  localparam int unsigned ND   = 2;
  localparam int unsigned RB   = 2;
  localparam int unsigned SLOT = 1 << RB;
  localparam int unsigned MAXC = 99;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        up_dn = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  load_val = 8'h00;
  logic [7:0]  count;
  logic [6:0]  seg;
  logic [1:0]  an;
  logic        tick, wrap;

  logic        load_b = 1'b0;
  logic [11:0] load_val_b = 12'h000;
  logic [11:0] count_b;
  logic [6:0]  seg_b;
  logic [2:0]  an_b;
  logic        tick_b, wrap_b;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int unsigned m_run, m_cnt, m_scan, m_scan_b;
  logic        m_tick, m_wrap;
  logic [11:0] m_val_b;

  bcd_updown_counter_mux #(
    .CLK_FREQ(8), .TICK_HZ(1), .NUM_DIGITS(2), .REFRESH_BITS(2), .BLANK_LZ(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count), .seg(seg), .an(an), .tick(tick), .wrap(wrap)
  );

  bcd_updown_counter_mux #(
    .CLK_FREQ(8), .TICK_HZ(1), .NUM_DIGITS(3), .REFRESH_BITS(2), .BLANK_LZ(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(1'b0), .up_dn(1'b1), .load(load_b), .load_val(load_val_b),
    .count(count_b), .seg(seg_b), .an(an_b), .tick(tick_b), .wrap(wrap_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic int unsigned clamp4(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic logic [7:0] to_bcd(input int unsigned v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_scan = 0; m_scan_b = 0;
    m_tick = 1'b0; m_wrap = 1'b0; m_val_b = '0;
  endtask

  // Behaviour of one rising edge, computed on the integer count value.
  task automatic model_step();
    logic old_tick, nt, nw;
    if (!rst_n) begin
      model_reset();
      return;
    end
    old_tick = m_tick;
    nw = 1'b0;
    if (en) begin
      m_run++;
      nt = (m_run % DIV == 0);
    end else begin
      m_run = 0;
      nt = 1'b0;
    end
    if (load) begin
      m_cnt = clamp4(load_val[7:4]) * 10 + clamp4(load_val[3:0]);
    end else if (old_tick && en) begin
      if (up_dn) begin
        if (m_cnt == MAXC) begin m_cnt = 0; nw = 1'b1; end
        else m_cnt++;
      end else begin
        if (m_cnt == 0) begin m_cnt = MAXC; nw = 1'b1; end
        else m_cnt--;
      end
    end
    m_tick   = nt;
    m_wrap   = nw;
    m_scan   = (m_scan + 1) % (ND * SLOT);
    m_scan_b = (m_scan_b + 1) % (3 * SLOT);
    if (load_b) begin
      for (int k = 0; k < 3; k++) m_val_b[4*k +: 4] = 4'(clamp4(load_val_b[4*k +: 4]));
    end
  endtask

  task automatic compare_all();
    int unsigned idx, dig, idxb;
    logic [3:0]  dig_b;
    logic        blank;
    idx = m_scan / SLOT;
    dig = (idx == 0) ? (m_cnt % 10) : (m_cnt / 10);
    chk("count", 32'(count), 32'(to_bcd(m_cnt)));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("an", 32'(an), 32'(3) & ~(32'(1) << idx));
    chk("seg", 32'(seg), 32'(seg_tab[dig]));
    idxb  = m_scan_b / SLOT;
    dig_b = m_val_b[4*idxb +: 4];
    blank = (idxb > 0) && ((m_val_b >> (4*idxb)) == 12'h000);
    chk("b_count", 32'(count_b), 32'(m_val_b));
    chk("b_an", 32'(an_b), 32'(7) & ~(32'(1) << idxb));
    chk("b_seg", 32'(seg_b), blank ? 32'h7F : 32'(seg_tab[dig_b]));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned wraps, n;
    logic [7:0]  prev;
    logic [11:0] bvals [5] = '{12'h007, 12'h107, 12'h000, 12'h020, 12'h0AF};

    model_reset();
    repeat (3) cyc();
    chk("rst_an", 32'(an), 32'b10);
    chk("rst_seg", 32'(seg), 32'b1000000);
    rst_n = 1'b1;

    // Free-running count up through a full roll-over.
    en = 1'b1; up_dn = 1'b1; wraps = 0;
    repeat (810) begin
      cyc();
      if (wrap) wraps++;
    end
    chk("up_wrap_once", wraps, 1);

    // Roll-under from 00.
    load_val = 8'h00; load = 1'b1; cyc(); load = 1'b0; up_dn = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (!wrap && n < 40);
    chk("dn_wrap_seen", 32'(wrap), 1);
    chk("dn_to_99", 32'(count), 32'h99);
    prev = count; n = 0;
    do begin cyc(); n++; end while (count == prev && n < 40);
    chk("dn_to_98", 32'(count), 32'h98);

    // Load coinciding with a tick.
    up_dn = 1'b1; n = 0;
    while (!tick && n < 20) begin cyc(); n++; end
    chk("tick_seen", 32'(tick), 1);
    load_val = 8'h5F; load = 1'b1; cyc(); load = 1'b0;
    chk("ld_pri_cnt", 32'(count), 32'h59);
    chk("ld_pri_wrap", 32'(wrap), 0);

    // Pause and resume latency.
    load_val = 8'h37; load = 1'b1; cyc(); load = 1'b0; en = 1'b0;
    repeat (20) begin cyc(); chk("pause_hold", 32'(count), 32'h37); end
    en = 1'b1; n = 1;
    do begin cyc(); n++; end while (!tick && n < 30);
    chk("pause_lat", n, 9);

    // Static display scan.
    en = 1'b0; load_val = 8'h42; load = 1'b1; cyc(); load = 1'b0;
    repeat (16) begin
      cyc();
      if (an == 2'b01) chk("scan_d1", 32'(seg), 32'b0011001);
      else             chk("scan_d0", 32'(seg), 32'b0100100);
    end

    // Blanking on the 3-digit instance.
    foreach (bvals[i]) begin
      load_val_b = bvals[i]; load_b = 1'b1; cyc(); load_b = 1'b0;
      repeat (12) cyc();
    end

    // Random traffic.
    en = 1'b1;
    repeat (2500) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) up_dn = ~up_dn;
      load = ($urandom_range(0, 63) == 0);
      load_val = 8'($urandom);
      cyc();
    end
    load = 1'b0;

    // Asynchronous reset in mid-count.
    en = 1'b1; load_val = 8'h55; load = 1'b1; load_val_b = 12'h321; load_b = 1'b1;
    cyc(); load = 1'b0; load_b = 1'b0; cyc();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_count", 32'(count), 0);
    chk("arst_tick", 32'(tick), 0);
    chk("arst_wrap", 32'(wrap), 0);
    chk("arst_an", 32'(an), 32'b10);
    chk("arst_b_count", 32'(count_b), 0);
    cyc();
    rst_n = 1'b1;
    repeat (20) cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
